// File: rtl/mesh_term_arbiter.sv
// Round-robin scheduler feeding one mesh terminal from NUM_REQ pending/pop packet sources.
// Optional build macro MESH_ARB_PRIO0_EN gives requester 0 strict priority over the rotation.
module mesh_term_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PAKG_SIZE = 32,
  parameter int STALL_MAX = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_pndng,
  input  logic [NUM_REQ*PAKG_SIZE-1:0]  req_data,
  output logic [NUM_REQ-1:0]            req_pop,
  output logic                          term_pndng,
  output logic [PAKG_SIZE-1:0]          term_data,
  input  logic                          term_popin,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [15:0]                   pkt_cnt,
  output logic                          stall
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int WW = $clog2(STALL_MAX + 2);
  localparam logic [WW-1:0] WAIT_LIM = WW'(STALL_MAX);
  localparam logic [WW-1:0] WAIT_SAT = WW'(STALL_MAX + 1);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [0:0]           state_r;
  logic [PAKG_SIZE-1:0] term_data_r;
  logic [GW-1:0]        grant_id_r;
  logic [GW-1:0]        last_grant_r;
  logic [15:0]          pkt_cnt_r;
  logic [WW-1:0]        wait_cnt_r;
  logic                 stall_r;

  logic                 win_found_s;
  logic [GW-1:0]        win_idx_s;
  logic [PAKG_SIZE-1:0] win_data_s;
  logic                 load_s;
  logic                 consume_s;
  int                   idx_s;

  // Winner search: first pending requester after last_grant, wrapping around.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    win_data_s  = '0;
    idx_s       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = (int'(last_grant_r) + 1 + i) % NUM_REQ;
      if (!win_found_s && req_pndng[idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_s[GW-1:0];
        win_data_s  = req_data[idx_s*PAKG_SIZE +: PAKG_SIZE];
      end else begin
        win_found_s = win_found_s;
      end
    end
`ifdef MESH_ARB_PRIO0_EN
    // Requester 0 overrides the rotation but last_grant still moves to 0.
    if (req_pndng[0]) begin
      win_found_s = 1'b1;
      win_idx_s   = '0;
      win_data_s  = req_data[PAKG_SIZE-1:0];
    end else begin
      win_found_s = win_found_s;
    end
`endif
  end

  // Load/consume qualification and the one-hot pop pulse; held quiet during reset.
  always_comb begin
    consume_s = (state_r == ST_PRESENT) && term_popin;
    load_s    = reset && win_found_s && ((state_r == ST_IDLE) || term_popin);
    if (load_s) begin
      req_pop = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
    end else begin
      req_pop = '0;
    end
  end

  // Output register and two-state FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      term_data_r  <= '0;
      grant_id_r   <= '0;
      last_grant_r <= GW'(NUM_REQ - 1);
    end else if (load_s) begin
      state_r      <= ST_PRESENT;
      term_data_r  <= win_data_s;
      grant_id_r   <= win_idx_s;
      last_grant_r <= win_idx_s;
    end else if (consume_s) begin
      state_r      <= ST_IDLE;
    end else begin
      state_r      <= state_r;
    end
  end

  // Delivered-packet counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt_r <= 16'd0;
    end else if (consume_s) begin
      pkt_cnt_r <= pkt_cnt_r + 16'd1;
    end else begin
      pkt_cnt_r <= pkt_cnt_r;
    end
  end

  // Wait counter and sticky stall flag; stall rises on the edge wait_cnt passes STALL_MAX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_r <= '0;
      stall_r    <= 1'b0;
    end else if (consume_s) begin
      wait_cnt_r <= '0;
      stall_r    <= 1'b0;
    end else if (state_r == ST_PRESENT) begin
      if (wait_cnt_r < WAIT_SAT) begin
        wait_cnt_r <= wait_cnt_r + {{(WW-1){1'b0}}, 1'b1};
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      if (wait_cnt_r >= WAIT_LIM) begin
        stall_r <= 1'b1;
      end else begin
        stall_r <= stall_r;
      end
    end else begin
      wait_cnt_r <= load_s ? '0 : wait_cnt_r;
      stall_r    <= stall_r;
    end
  end

  assign term_pndng = (state_r == ST_PRESENT);
  assign term_data  = term_data_r;
  assign grant_id   = grant_id_r;
  assign pkt_cnt    = pkt_cnt_r;
  assign stall      = stall_r;

endmodule

// File: tb/tb_mesh_term_arbiter.sv
// Directed self-checking bench for mesh_term_arbiter (NUM_REQ=4, PAKG_SIZE=32, STALL_MAX=64).
module tb_mesh_term_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req_pndng;
  logic [127:0] req_data;
  logic [3:0]   req_pop;
  logic         term_pndng;
  logic [31:0]  term_data;
  logic         term_popin;
  logic [1:0]   grant_id;
  logic [15:0]  pkt_cnt;
  logic         stall;

  int total = 0;
  int bad   = 0;

  mesh_term_arbiter #(.NUM_REQ(4), .PAKG_SIZE(32), .STALL_MAX(64)) dut (
    .clk(clk), .reset(reset), .req_pndng(req_pndng), .req_data(req_data),
    .req_pop(req_pop), .term_pndng(term_pndng), .term_data(term_data),
    .term_popin(term_popin), .grant_id(grant_id), .pkt_cnt(pkt_cnt), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b0; req_pndng = 4'b0000; term_popin = 1'b0;
    req_data = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_pndng = 4'b0000; term_popin = 1'b0; req_data = '0;
    #3;
    total++; if (term_pndng !== 1'b0) begin bad++; $display("FAIL rst_pndng got=%b exp=0", term_pndng); end
    total++; if (term_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", term_data); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant got=%0d exp=0", grant_id); end
    total++; if (pkt_cnt !== 16'h0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", pkt_cnt); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
    total++; if (req_pop !== 4'b0000) begin bad++; $display("FAIL rst_pop got=%b exp=0000", req_pop); end
  endtask

  task automatic test_single();
    do_reset();
    req_data[64 +: 32] = 32'h0000_00A5; req_pndng = 4'b0100; term_popin = 1'b1;
    #1;
    total++; if (req_pop !== 4'b0100) begin bad++; $display("FAIL single_pop got=%b exp=0100", req_pop); end
    @(posedge clk); #1;
    req_pndng = 4'b0000; #1;
    total++; if (req_pop !== 4'b0000) begin bad++; $display("FAIL single_pop2 got=%b exp=0000", req_pop); end
    total++; if (term_pndng !== 1'b1) begin bad++; $display("FAIL single_pndng got=%b exp=1", term_pndng); end
    total++; if (term_data !== 32'h0000_00A5) begin bad++; $display("FAIL single_data got=%h exp=000000a5", term_data); end
    total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL single_grant got=%0d exp=2", grant_id); end
    total++; if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL single_cnt0 got=%0d exp=0", pkt_cnt); end
    @(posedge clk); #1;
    total++; if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt1 got=%0d exp=1", pkt_cnt); end
    total++; if (term_pndng !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", term_pndng); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_pop;
    do_reset();
    req_pndng = 4'b1111; term_popin = 1'b1; #1;
    total++; if (req_pop !== 4'b0001) begin bad++; $display("FAIL fair_pop0 got=%b exp=0001", req_pop); end
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      exp_pop = 4'b0001 << (n % 4);
      total++; if (grant_id !== 2'((n - 1) % 4)) begin bad++; $display("FAIL fair_grant n=%0d got=%0d exp=%0d", n, grant_id, (n - 1) % 4); end
      total++; if (term_data !== 32'h1000_0000 + 32'((n - 1) % 4)) begin bad++; $display("FAIL fair_data n=%0d got=%h", n, term_data); end
      total++; if (req_pop !== exp_pop) begin bad++; $display("FAIL fair_pop n=%0d got=%b exp=%b", n, req_pop, exp_pop); end
      total++; if (pkt_cnt !== 16'(n - 1)) begin bad++; $display("FAIL fair_cnt n=%0d got=%0d exp=%0d", n, pkt_cnt, n - 1); end
    end
    total++; if (pkt_cnt !== 16'd8) begin bad++; $display("FAIL fair_cnt8 got=%0d exp=8", pkt_cnt); end
  endtask

  task automatic test_stall();
    do_reset();
    req_data[32 +: 32] = 32'hCAFE_0001; req_pndng = 4'b0010; term_popin = 1'b0; #1;
    total++; if (req_pop !== 4'b0010) begin bad++; $display("FAIL stall_pop0 got=%b exp=0010", req_pop); end
    @(posedge clk); #1;
    req_data[32 +: 32] = 32'hCAFE_0002;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      total++; if (stall !== (k >= 65)) begin bad++; $display("FAIL stall_flag k=%0d got=%b exp=%b", k, stall, k >= 65); end
      total++; if (req_pop !== 4'b0000) begin bad++; $display("FAIL stall_nopop k=%0d got=%b exp=0000", k, req_pop); end
      total++; if (term_data !== 32'hCAFE_0001) begin bad++; $display("FAIL stall_hold k=%0d got=%h exp=cafe0001", k, term_data); end
    end
    term_popin = 1'b1; #1;
    total++; if (req_pop !== 4'b0010) begin bad++; $display("FAIL stall_reload got=%b exp=0010", req_pop); end
    @(posedge clk); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_clear got=%b exp=0", stall); end
    total++; if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL stall_cnt got=%0d exp=1", pkt_cnt); end
    total++; if (term_data !== 32'hCAFE_0002) begin bad++; $display("FAIL stall_next got=%h exp=cafe0002", term_data); end
    req_pndng = 4'b0000;
    @(posedge clk); #1;
    total++; if (term_pndng !== 1'b0 || pkt_cnt !== 16'd2) begin bad++; $display("FAIL stall_drain got=%b/%0d exp=0/2", term_pndng, pkt_cnt); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    req_pndng = 4'b1111; term_popin = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    total++; if (pkt_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff got=%h exp=ffff", pkt_cnt); end
    @(posedge clk); #1;
    total++; if (pkt_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h exp=0000", pkt_cnt); end
    req_pndng = 4'b1000; #1;
    total++; if (req_pop !== 4'b1000) begin bad++; $display("FAIL mid_pop got=%b exp=1000", req_pop); end
    @(posedge clk); #1;
    term_popin = 1'b0; #1;
    total++; if (grant_id !== 2'd3 || term_pndng !== 1'b1) begin bad++; $display("FAIL mid_present got=%0d/%b exp=3/1", grant_id, term_pndng); end
    reset = 1'b0; #1;
    total++; if (term_pndng !== 1'b0) begin bad++; $display("FAIL mid_rst_pndng got=%b exp=0", term_pndng); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL mid_rst_grant got=%0d exp=0", grant_id); end
    total++; if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d exp=0", pkt_cnt); end
    total++; if (req_pop !== 4'b0000) begin bad++; $display("FAIL mid_rst_pop got=%b exp=0000", req_pop); end
    req_pndng = 4'b1001; term_popin = 1'b1;
    @(negedge clk); reset = 1'b1; #1;
    total++; if (req_pop !== 4'b0001) begin bad++; $display("FAIL post_rst_pop got=%b exp=0001", req_pop); end
    @(posedge clk); #1;
    total++; if (grant_id !== 2'd0 || term_data !== 32'h1000_0000) begin bad++; $display("FAIL post_rst_grant got=%0d/%h exp=0/10000000", grant_id, term_data); end
  endtask

  task automatic test_two_sources();
    logic [1:0] exp_g;
    do_reset();
    req_pndng = 4'b0101; term_popin = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
`ifdef MESH_ARB_PRIO0_EN
      exp_g = 2'd0;
`else
      exp_g = (n % 2 == 1) ? 2'd0 : 2'd2;
`endif
      total++; if (grant_id !== exp_g) begin bad++; $display("FAIL two_grant n=%0d got=%0d exp=%0d", n, grant_id, exp_g); end
    end
    req_pndng = 4'b0100; #1;
    total++; if (req_pop !== 4'b0100) begin bad++; $display("FAIL two_drop_pop got=%b exp=0100", req_pop); end
    @(posedge clk); #1;
    total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL two_drop_grant got=%0d exp=2", grant_id); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_two_sources();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mesh_term_arbiter.md
# mesh_term_arbiter

Round-robin scheduler that lets NUM_REQ independent packet sources share one terminal input port of the mesh router network. It pulls packets from requester queues with a pending/pop handshake, holds one packet in an output register, and presents it to the mesh terminal with the same pending/pop handshake the mesh uses (`pndng_i_in` / `data_out_i_in` / `popin`). It sits between the per-terminal traffic sources (agents, DMA-like producers) and one terminal of the mesh. It also keeps delivery and stall statistics.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; 2..8.
- `PAKG_SIZE`, 32: packet width in bits, identical to the mesh `pckg_sz`.
- `STALL_MAX`, 64: cycles a presented packet may wait for `popin` before the stall flag is raised; ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_pndng`  in  NUM_REQ  bit i = requester i has a packet at the head of its queue.
- `req_data`  in  NUM_REQ*PAKG_SIZE  head packet of requester i in bits [i*PAKG_SIZE +: PAKG_SIZE].
- `req_pop`  out  NUM_REQ  one-hot, one-cycle pulse; requester i removes its head packet at that edge.
- `term_pndng`  out  1  drives the mesh `pndng_i_in` for this terminal.
- `term_data`  out  PAKG_SIZE  drives the mesh `data_out_i_in` for this terminal.
- `term_popin`  in  1  the mesh `popin` for this terminal; the packet is consumed at the edge where `term_pndng` & `term_popin`.
- `grant_id`  out  $clog2(NUM_REQ)  source index of the packet currently in the output register.
- `pkt_cnt`  out  16  packets delivered to the mesh; wraps from 0xFFFF to 0.
- `stall`  out  1  sticky flag; set when one packet has waited more than STALL_MAX cycles.

## Operation
- FSM with two states:
  - `IDLE`: output register empty, `term_pndng` = 0.
  - `PRESENT`: output register full, `term_pndng` = 1.
- Load event, allowed when in `IDLE`, or in `PRESENT` with a consume happening that same edge:
  - If any `req_pndng` bit is set, select the winner g by round-robin.
  - Search starts at (`last_grant`+1) mod NUM_REQ and wraps.
  - Pulse `req_pop[g]` combinationally in that cycle.
  - At the edge: register `req_data[g]` into `term_data`, set `grant_id`=g and `last_grant`=g, go to (or stay in) `PRESENT`.
- Consume (`PRESENT` & `term_popin`):
  - `pkt_cnt` += 1.
  - If no requester is pending, go to `IDLE`; otherwise reload in the same edge (back-to-back).
- `term_data` and `grant_id` are held stable for the whole time `term_pndng` is 1.
- `req_pop` is never asserted without the matching `req_pndng` bit, and never while `PRESENT` without `term_popin`.
- Stall detection:
  - `wait_cnt` counts cycles in `PRESENT` without a consume and saturates at STALL_MAX+1.
  - When `wait_cnt` > STALL_MAX, `stall` is set.
  - `stall` clears only on the next consume. `wait_cnt` is zeroed on every load.
- `term_popin` in `IDLE` is ignored; no counter changes.

## Timing
- Reset values, applied asynchronously while `reset`=0:
  - state `IDLE`; `term_pndng`=0; `term_data`=0; `grant_id`=0.
  - `last_grant`=NUM_REQ-1, so requester 0 wins first.
  - `pkt_cnt`=0; `wait_cnt`=0; `stall`=0; `req_pop`=0.
- Reset mid-`PRESENT` drops the registered packet. The source has already popped it, so the packet is lost; this is accepted behaviour.
- Latency: `req_pndng` rises at edge k → `req_pop` pulse in cycle k → `term_pndng`=1 after edge k+1.
- Throughput: 1 packet/cycle while `term_popin` is held high and requesters stay pending.
- `req_pop` is combinational from registered state, `req_pndng` and `term_popin`. Requesters must not make `req_pndng` depend combinationally on `req_pop`.

## Configuration
- `MESH_ARB_PRIO0_EN`:
  - Defined: requester 0 has strict priority. Whenever `req_pndng[0]`=1 at a load event it wins, regardless of round-robin. `last_grant` still updates to 0, so the remaining requesters stay in round-robin among themselves.
  - Undefined: pure round-robin over all NUM_REQ requesters.

## Test plan
- Single source: reset, requester 2 pending with 0x0000_00A5, `term_popin`=1 → `req_pop`=0b0100 for one cycle; next cycle `term_pndng`=1, `term_data`=0x0000_00A5, `grant_id`=2; `pkt_cnt`=1 after the following edge; then `IDLE`.
- Fairness: all 4 requesters always pending, `term_popin`=1 → grant order 0,1,2,3,0,1… at one packet per cycle; after 8 cycles of delivery `pkt_cnt`=8.
- Backpressure/stall: requester 1 pending, `term_popin`=0 for 70 cycles (STALL_MAX=64) → `term_data` stable; `stall`=1 from 65 cycles after presentation; no further `req_pop`; raise `term_popin` → `stall`=0, `pkt_cnt`+1.
- Counter wrap: preload traffic to `pkt_cnt`=0xFFFF, deliver one packet → `pkt_cnt`=0x0000.
- Reset mid-operation: `reset`=0 while `PRESENT` with `grant_id`=3 → immediately `term_pndng`=0, `grant_id`=0, `pkt_cnt`=0; after release with requesters 0 and 3 pending, requester 0 wins first.
- With `MESH_ARB_PRIO0_EN` defined: requesters 0 and 2 always pending → every grant is 0. Drop `req_pndng[0]` → grant 2.
